seg7_capture: RTL and testbench

Seven-segment pattern receiver for the DE2 board designs. Samples an external active-low 7-segment bus (the same encoding our display drivers put on the HEX outputs), synchronizes it, and rejects glitches by requiring a pattern to hold for a programmable number of cycles. Decodes the stable pattern back to a digit value and reports blank and illegal patterns. Used to loop back and check display drivers, or to read another board's display lines.

---
 rtl/seg7_capture_if.sv | 19 +
 rtl/seg7_capture.sv | 125 ++++++++++++
 tb/tb_seg7_capture.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// Segment bus and decoded-result signals shared between a 7-segment source and seg7_capture.
interface seg7_capture_if;
    logic [0:6] SEG_IN;
    logic [3:0] DIGIT;
    logic       DIG_VALID;
    logic       BLANK;
    logic       ERR;
    logic [7:0] CHANGES;

    modport master (
        output SEG_IN,
        input  DIGIT, DIG_VALID, BLANK, ERR, CHANGES
    );

    modport slave (
        input  SEG_IN,
        output DIGIT, DIG_VALID, BLANK, ERR, CHANGES
    );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: synchronizes an active-low 7-segment bus, waits for a stable glyph and decodes it.
// Define SEG7_CAPTURE_HEX_EN to also accept the A, b, C, d, E, F glyphs as digits 10..15.
module seg7_capture #(
    parameter int STABLE_CYCLES = 50000
) (
    input  logic          CLOCK_50,
    input  logic          V_KEY,
    seg7_capture_if.slave bus
);
    localparam logic [19:0] CNT_LAST  = 20'(STABLE_CYCLES - 1);
    localparam logic [0:6]  SEG_BLANK = 7'b1111111;

    typedef enum logic {SETTLING, STABLE} state_t;

    state_t      state, state_next;
    logic [0:6]  sync1, sync2;
    logic [0:6]  cand, cand_next;
    logic [0:6]  acc, acc_next;
    logic [19:0] cnt, cnt_next;
    logic [3:0]  digit, digit_next;
    logic        dig_valid, dig_valid_next;
    logic        blank, blank_next;
    logic        err, err_next;
    logic [7:0]  changes, changes_next;
    logic [4:0]  glyph;

    // Returns {legal, value}; blank is handled by the caller before decode.
    function automatic logic [4:0] decode(input logic [0:6] seg);
        case (seg)
            7'b0000001: return {1'b1, 4'd0};
            7'b1001111: return {1'b1, 4'd1};
            7'b0010010: return {1'b1, 4'd2};
            7'b0000110: return {1'b1, 4'd3};
            7'b1001100: return {1'b1, 4'd4};
            7'b0100100: return {1'b1, 4'd5};
            7'b0100000: return {1'b1, 4'd6};
            7'b0001111: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0000100: return {1'b1, 4'd9};
`ifdef SEG7_CAPTURE_HEX_EN
            7'b0001000: return {1'b1, 4'd10};
            7'b1100000: return {1'b1, 4'd11};
            7'b0110001: return {1'b1, 4'd12};
            7'b1000010: return {1'b1, 4'd13};
            7'b0110000: return {1'b1, 4'd14};
            7'b0111000: return {1'b1, 4'd15};
`endif
            default:    return {1'b0, 4'd0};
        endcase
    endfunction

    always_comb begin
        state_next     = state;
        cand_next      = cand;
        cnt_next       = cnt;
        acc_next       = acc;
        digit_next     = digit;
        dig_valid_next = 1'b0;
        blank_next     = blank;
        err_next       = err;
        changes_next   = changes;
        glyph          = decode(cand);

        if (sync2 != cand) begin
            cand_next  = sync2;
            cnt_next   = '0;
            state_next = SETTLING;
        end else if (cnt < CNT_LAST) begin
            cnt_next = cnt + 20'd1;
        end else begin
            // Counter saturates here; only a pattern differing from the accepted one pulses.
            state_next = STABLE;
            if (cand != acc) begin
                acc_next       = cand;
                dig_valid_next = 1'b1;
                changes_next   = changes + 8'd1;
                if (cand == SEG_BLANK) begin
                    blank_next = 1'b1;
                    err_next   = 1'b0;
                end else if (glyph[4]) begin
                    digit_next = glyph[3:0];
                    blank_next = 1'b0;
                    err_next   = 1'b0;
                end else begin
                    blank_next = 1'b0;
                    err_next   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge V_KEY) begin
        if (!V_KEY) begin
            sync1     <= SEG_BLANK;
            sync2     <= SEG_BLANK;
            cand      <= SEG_BLANK;
            acc       <= SEG_BLANK;
            cnt       <= '0;
            state     <= SETTLING;
            digit     <= '0;
            dig_valid <= 1'b0;
            blank     <= 1'b1;
            err       <= 1'b0;
            changes   <= '0;
        end else begin
            sync1     <= bus.SEG_IN;
            sync2     <= sync1;
            cand      <= cand_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            state     <= state_next;
            digit     <= digit_next;
            dig_valid <= dig_valid_next;
            blank     <= blank_next;
            err       <= err_next;
            changes   <= changes_next;
        end
    end

    assign bus.DIGIT     = digit;
    assign bus.DIG_VALID = dig_valid;
    assign bus.BLANK     = blank;
    assign bus.ERR       = err;
    assign bus.CHANGES   = changes;
endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture with STABLE_CYCLES=4 and a run-length reference model.
module tb_seg7_capture;
    localparam int S = 4;
`ifdef SEG7_CAPTURE_HEX_EN
    localparam int N_LEGAL = 16;
`else
    localparam int N_LEGAL = 10;
`endif
    localparam logic [14:0] RESET_OBS = {1'b0, 4'd0, 1'b1, 1'b0, 8'd0};

    logic CLOCK_50 = 1'b0;
    logic V_KEY = 1'b1;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .CLOCK_50 (CLOCK_50),
        .V_KEY    (V_KEY),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    logic [0:6] glyph [16];

    logic [0:6] m_d1, m_d2, m_val, m_acc, m_cur;
    int         m_run;
    logic       m_valid, m_blank, m_err;
    logic [3:0] m_digit;
    logic [7:0] m_changes;

    logic [14:0] obs, expv;
    assign obs  = {bus.DIG_VALID, bus.DIGIT, bus.BLANK, bus.ERR, bus.CHANGES};
    assign expv = {m_valid, m_digit, m_blank, m_err, m_changes};

    // Model: the value judged at an edge is the input sampled two edges earlier; a value is
    // accepted once it has been seen on S+1 consecutive edges and differs from the last accepted one.
    always @(posedge CLOCK_50 or negedge V_KEY) begin
        if (!V_KEY) begin
            m_d1 = 7'b1111111; m_d2 = 7'b1111111; m_val = 7'b1111111; m_acc = 7'b1111111;
            m_run = 1; m_valid = 1'b0; m_digit = 4'd0; m_blank = 1'b1; m_err = 1'b0;
            m_changes = 8'd0;
        end else begin
            m_cur = m_d2;
            m_d2 = m_d1;
            m_d1 = bus.SEG_IN;
            m_valid = 1'b0;
            if (m_cur != m_val) begin
                m_val = m_cur;
                m_run = 1;
            end else begin
                if (m_run <= S) m_run++;
                if (m_run == S + 1 && m_val != m_acc) begin
                    m_acc = m_val;
                    m_valid = 1'b1;
                    m_changes = m_changes + 8'd1;
                    if (m_val == 7'b1111111) begin
                        m_blank = 1'b1;
                        m_err = 1'b0;
                    end else begin
                        m_blank = 1'b0;
                        m_err = 1'b1;
                        for (int i = 0; i < N_LEGAL; i++)
                            if (glyph[i] == m_val) begin
                                m_digit = 4'(i);
                                m_err = 1'b0;
                            end
                    end
                end
            end
        end
    end

    task automatic test_reset;
        int pulses;
        pulses = 0;
        bus.SEG_IN = 7'b1111111;
        #5 V_KEY = 1'b0;
        #1;
        total++;
        if (obs !== RESET_OBS) begin
            bad++;
            $display("[TB] FAIL reset_values: got %h expected %h", obs, RESET_OBS);
        end
        repeat (2) @(negedge CLOCK_50);
        V_KEY = 1'b1;
        repeat (20) begin
            @(negedge CLOCK_50);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL startup_cycle: got %h expected %h", obs, expv);
            end
            if (bus.DIG_VALID) pulses++;
        end
        total++;
        if (pulses != 0 || bus.BLANK !== 1'b1 || bus.DIGIT !== 4'd0 || bus.CHANGES !== 8'd0) begin
            bad++;
            $display("[TB] FAIL startup_blank: got pulses=%0d blank=%b digit=%0d changes=%0d expected 0 1 0 0",
                     pulses, bus.BLANK, bus.DIGIT, bus.CHANGES);
        end
    endtask

    task automatic test_first_accept;
        int pulses, pulse_edge;
        pulses = 0;
        pulse_edge = 0;
        bus.SEG_IN = 7'b0010010;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLOCK_50);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL first_accept_cycle%0d: got %h expected %h", k, obs, expv);
            end
            if (bus.DIG_VALID) begin
                pulses++;
                pulse_edge = k;
            end
        end
        total++;
        if (pulses != 1 || pulse_edge != 7 || bus.DIGIT !== 4'd2 || bus.BLANK !== 1'b0 ||
            bus.ERR !== 1'b0 || bus.CHANGES !== 8'd1) begin
            bad++;
            $display("[TB] FAIL first_accept: got pulses=%0d edge=%0d digit=%0d blank=%b err=%b changes=%0d expected 1 7 2 0 0 1",
                     pulses, pulse_edge, bus.DIGIT, bus.BLANK, bus.ERR, bus.CHANGES);
        end
    endtask

    task automatic test_glitch;
        int pulses;
        pulses = 0;
        bus.SEG_IN = 7'b0000110;
        for (int k = 0; k < 14; k++) begin
            if (k == 2) bus.SEG_IN = 7'b0010010;
            @(negedge CLOCK_50);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL glitch_cycle%0d: got %h expected %h", k, obs, expv);
            end
            if (bus.DIG_VALID) pulses++;
        end
        total++;
        if (pulses != 0 || bus.DIGIT !== 4'd2 || bus.CHANGES !== 8'd1) begin
            bad++;
            $display("[TB] FAIL glitch_reject: got pulses=%0d digit=%0d changes=%0d expected 0 2 1",
                     pulses, bus.DIGIT, bus.CHANGES);
        end
    endtask

    task automatic test_sweep;
        int pulses;
        logic [3:0] seen;
        bus.SEG_IN = 7'b1111111;
        V_KEY = 1'b0;
        @(negedge CLOCK_50);
        V_KEY = 1'b1;
        for (int d = 0; d < 10; d++) begin
            pulses = 0;
            seen = 4'hx;
            bus.SEG_IN = glyph[d];
            repeat (10) begin
                @(negedge CLOCK_50);
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("[TB] FAIL sweep_cycle: got %h expected %h", obs, expv);
                end
                if (bus.DIG_VALID) begin
                    pulses++;
                    seen = bus.DIGIT;
                end
            end
            total++;
            if (pulses != 1 || seen !== 4'(d)) begin
                bad++;
                $display("[TB] FAIL sweep_digit%0d: got pulses=%0d digit=%0d expected 1 %0d", d, pulses, seen, d);
            end
        end
        total++;
        if (bus.CHANGES !== 8'd10) begin
            bad++;
            $display("[TB] FAIL sweep_changes: got %0d expected 10", bus.CHANGES);
        end
    endtask

    task automatic test_hex;
        int pulses;
        pulses = 0;
        bus.SEG_IN = 7'b0001000;
        repeat (10) begin
            @(negedge CLOCK_50);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL hex_cycle: got %h expected %h", obs, expv);
            end
            if (bus.DIG_VALID) pulses++;
        end
        total++;
`ifdef SEG7_CAPTURE_HEX_EN
        if (pulses != 1 || bus.DIGIT !== 4'd10 || bus.ERR !== 1'b0 || bus.BLANK !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hex_a: got pulses=%0d digit=%0d err=%b blank=%b expected 1 10 0 0",
                     pulses, bus.DIGIT, bus.ERR, bus.BLANK);
        end
`else
        if (pulses != 1 || bus.DIGIT !== 4'd9 || bus.ERR !== 1'b1 || bus.BLANK !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hex_a: got pulses=%0d digit=%0d err=%b blank=%b expected 1 9 1 0",
                     pulses, bus.DIGIT, bus.ERR, bus.BLANK);
        end
`endif
    endtask

    task automatic test_random;
        int hold;
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 1) == 0) bus.SEG_IN = glyph[$urandom_range(0, 15)];
            else bus.SEG_IN = 7'($urandom);
            hold = $urandom_range(1, 8);
            repeat (hold) begin
                @(negedge CLOCK_50);
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("[TB] FAIL random_cycle: in=%b got %h expected %h", bus.SEG_IN, obs, expv);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int pulses;
        pulses = 0;
        bus.SEG_IN = 7'b1111111;
        V_KEY = 1'b0;
        @(negedge CLOCK_50);
        V_KEY = 1'b1;
        for (int p = 0; p < 257; p++) begin
            bus.SEG_IN = (p % 2 == 0) ? glyph[1] : glyph[7];
            if (p == 256) bus.SEG_IN = glyph[7];
            repeat (6) begin
                @(negedge CLOCK_50);
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("[TB] FAIL wrap_cycle: got %h expected %h", obs, expv);
                end
                if (bus.DIG_VALID) pulses++;
            end
        end
        total++;
        if (pulses != 256 || bus.CHANGES !== 8'd0) begin
            bad++;
            $display("[TB] FAIL wrap_changes: got pulses=%0d changes=%0d expected 256 0", pulses, bus.CHANGES);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 1'b0;
        bus.SEG_IN = glyph[5];
        repeat (4) @(negedge CLOCK_50);
        #3 V_KEY = 1'b0;
        #1;
        total++;
        if (obs !== RESET_OBS) begin
            bad++;
            $display("[TB] FAIL reset_mid_count: got %h expected %h", obs, RESET_OBS);
        end
        @(negedge CLOCK_50);
        V_KEY = 1'b1;
        bus.SEG_IN = glyph[4];
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge CLOCK_50);
            if (bus.DIG_VALID) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL reset_pulse_timeout: got no pulse expected one within 12 cycles");
        end else begin
            #3 V_KEY = 1'b0;
            #1;
            if (obs !== RESET_OBS) begin
                bad++;
                $display("[TB] FAIL reset_during_pulse: got %h expected %h", obs, RESET_OBS);
            end
        end
        @(negedge CLOCK_50);
        V_KEY = 1'b1;
    endtask

    initial begin
        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
        glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
        glyph[15] = 7'b0111000;
        bus.SEG_IN = 7'b1111111;
        $display("[TB] starting seg7_capture bench, STABLE_CYCLES=%0d", S);
        test_reset();
        test_first_accept();
        test_glitch();
        test_sweep();
        test_hex();
        test_random();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
